alu_flags: RTL and testbench

The F register and carry-chain sequencer sitting directly downstream of the ALU. It consumes the ALU's per-operation zero, half-carry and carry results and commits them into Z/N/H/C under decoder control. It feeds the held flags back to the ALU as Temp_Z/N/H/C and as the ALU carry-in. It also sequences the two-byte carry chain for 16-bit adds, and evaluates branch conditions.

---
 rtl/alu_flags_pkg.sv | 30 +++
 rtl/alu_flags_cond.sv | 21 ++
 rtl/alu_flags.sv | 118 +++++++++++
 tb/tb_alu_flags.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_flags_pkg.sv
// Shared encodings for the flag register: F bit positions, flag sources,
// branch conditions and the 16-bit carry-chain sequencer states.
package alu_flags_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_BUS = 2'd1,
    SRC_SCF = 2'd2,
    SRC_CCF = 2'd3
  } flag_src_e;

  typedef enum logic [1:0] {
    COND_NZ = 2'd0,
    COND_Z  = 2'd1,
    COND_NC = 2'd2,
    COND_C  = 2'd3
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_flags_cond.sv
// Branch condition evaluation from IR[4:3] against the registered flags.
module alu_flags_cond
  import alu_flags_pkg::*;
(
  input  logic [1:0] cond,
  input  logic [3:0] f,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      COND_NZ: cond_true = ~f[FLAG_Z];
      COND_Z:  cond_true =  f[FLAG_Z];
      COND_NC: cond_true = ~f[FLAG_C];
      COND_C:  cond_true =  f[FLAG_C];
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flags.sv
// F register {Z,N,H,C}, ALU carry-in feedback and 16-bit add carry-chain
// sequencer. ALU_FLAGS_COND_EN enables branch-condition evaluation.
module alu_flags
  import alu_flags_pkg::*;
(
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       alu_valid,
  input  logic       alu_z,
  input  logic       alu_h,
  input  logic       alu_c,
  input  logic       op_n,
  input  logic       carry_use,
  input  logic [3:0] upd_mask,
  input  logic [1:0] flag_src,
  input  logic [7:0] bus_in,
  input  logic       wide_start,
  input  logic       wide_kind,
  input  logic [1:0] cond,
  output logic       Temp_Z,
  output logic       Temp_N,
  output logic       Temp_H,
  output logic       Temp_C,
  output logic [7:0] f_out,
  output logic       carry_in,
  output logic       cond_true,
  output logic       busy
);

  state_e     state, state_nxt;
  logic [3:0] f, f_nxt, src;
  logic       kind, kind_nxt;
  logic       carry_link, link_nxt;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state      <= ST_IDLE;
      f          <= 4'h0;
      kind       <= 1'b0;
      carry_link <= 1'b0;
    end else begin
      state      <= state_nxt;
      f          <= f_nxt;
      kind       <= kind_nxt;
      carry_link <= link_nxt;
    end
  end

  // SCF/CCF never touch Z, so their Z source is the held value.
  always_comb begin
    src = f;
    case (flag_src_e'(flag_src))
      SRC_ALU: src = {alu_z, op_n, alu_h, alu_c};
      SRC_BUS: src = bus_in[7:4];
      SRC_SCF: src = {f[FLAG_Z], 1'b0, 1'b0, 1'b1};
      SRC_CCF: src = {f[FLAG_Z], 1'b0, 1'b0, ~f[FLAG_C]};
      default: src = f;
    endcase
  end

  always_comb begin
    state_nxt = state;
    f_nxt     = f;
    kind_nxt  = kind;
    link_nxt  = carry_link;
    carry_in  = 1'b0;
    case (state)
      ST_IDLE: begin
        carry_in = carry_use & f[FLAG_C];
        if (alu_valid) f_nxt = (f & ~upd_mask) | (src & upd_mask);
        if (wide_start) begin
          state_nxt = ST_LO;
          kind_nxt  = wide_kind;
        end
      end
      ST_LO: begin
        if (alu_valid) begin
          link_nxt = alu_c;
          if (kind) f_nxt = {1'b0, 1'b0, alu_h, alu_c};
          state_nxt = ST_HI;
        end
      end
      ST_HI: begin
        carry_in = carry_link;
        if (alu_valid) begin
          if (!kind) f_nxt = {f[FLAG_Z], 1'b0, alu_h, alu_c};
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign Temp_Z = f[FLAG_Z];
  assign Temp_N = f[FLAG_N];
  assign Temp_H = f[FLAG_H];
  assign Temp_C = f[FLAG_C];
  assign f_out  = {f, 4'b0000};
  assign busy   = (state != ST_IDLE);

`ifdef ALU_FLAGS_COND_EN
  logic cond_raw;

  alu_flags_cond u_cond (
    .cond      (cond),
    .f         (f),
    .cond_true (cond_raw)
  );

  // F is zero in reset, which would make NZ read true; hold it low instead.
  assign cond_true = nRESET & cond_raw;
`else
  logic unused_cond;
  assign unused_cond = ^cond;
  assign cond_true   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_flags.sv
// Scoreboard bench for alu_flags: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_alu_flags;

`ifdef ALU_FLAGS_COND_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       alu_valid, alu_z, alu_h, alu_c, op_n, carry_use;
  logic [3:0] upd_mask;
  logic [1:0] flag_src;
  logic [7:0] bus_in;
  logic       wide_start, wide_kind;
  logic [1:0] cond;
  logic       Temp_Z, Temp_N, Temp_H, Temp_C;
  logic [7:0] f_out;
  logic       carry_in, cond_true, busy;

  alu_flags dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .alu_valid  (alu_valid),
    .alu_z      (alu_z),
    .alu_h      (alu_h),
    .alu_c      (alu_c),
    .op_n       (op_n),
    .carry_use  (carry_use),
    .upd_mask   (upd_mask),
    .flag_src   (flag_src),
    .bus_in     (bus_in),
    .wide_start (wide_start),
    .wide_kind  (wide_kind),
    .cond       (cond),
    .Temp_Z     (Temp_Z),
    .Temp_N     (Temp_N),
    .Temp_H     (Temp_H),
    .Temp_C     (Temp_C),
    .f_out      (f_out),
    .carry_in   (carry_in),
    .cond_true  (cond_true),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] f;
    logic       ci;
    logic       ct;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: compares every pending expectation against the outputs.
  always @(negedge CLK) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [7:0] temp_f;
      e = q.pop_front();
      temp_f = {Temp_Z, Temp_N, Temp_H, Temp_C, 4'b0000};
      checks++;
      if (f_out !== e.f || temp_f !== e.f || carry_in !== e.ci ||
          cond_true !== e.ct || busy !== e.busy) begin
        failures++;
        $display("FAIL %s: got f_out=%h temp=%h carry_in=%b cond_true=%b busy=%b, want f_out=%h carry_in=%b cond_true=%b busy=%b",
                 e.name, f_out, temp_f, carry_in, cond_true, busy,
                 e.f, e.ci, e.ct, e.busy);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] f, input logic ci,
                     input logic ct, input logic b);
    exp_t e;
    e.name = name; e.f = f; e.ci = ci; e.ct = ct & COND_EN; e.busy = b;
    q.push_back(e);
    @(negedge CLK);
    #1;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    alu_valid = 0; alu_z = 0; alu_h = 0; alu_c = 0; op_n = 0;
    upd_mask = 4'h0; flag_src = 2'd0; bus_in = 8'h00;
    wide_start = 0; wide_kind = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nRESET = 0; carry_use = 0; cond = 2'd0;
    clr();
    repeat (2) cyc();
    chk("reset", 8'h00, 0, 0, 0);
    nRESET = 1;
    chk("release_nz", 8'h00, 0, 1, 0);

    // ALU commit of all four flags
    alu_valid = 1; upd_mask = 4'hF; flag_src = 2'd0;
    alu_z = 1; op_n = 1; alu_h = 0; alu_c = 1; cond = 2'd3;
    cyc(); clr();
    chk("alu_commit", 8'hD0, 0, 1, 0);
    carry_use = 1;
    chk("adc_ci", 8'hD0, 1, 1, 0);
    carry_use = 0; cond = 2'd0;
    chk("nz_false", 8'hD0, 0, 0, 0);

    // POP AF then CCF
    alu_valid = 1; flag_src = 2'd1; bus_in = 8'hA5; upd_mask = 4'hF; cond = 2'd2;
    cyc(); clr();
    chk("pop_af", 8'hA0, 0, 1, 0);
    alu_valid = 1; flag_src = 2'd3; upd_mask = 4'h7; cond = 2'd3;
    cyc(); clr();
    chk("ccf", 8'h90, 0, 1, 0);

    // Partial masks: only Z written
    alu_valid = 1; flag_src = 2'd0; upd_mask = 4'h8;
    alu_z = 0; op_n = 1; alu_h = 1; alu_c = 0; cond = 2'd1;
    cyc(); clr();
    chk("mask_z", 8'h10, 0, 0, 0);
    alu_valid = 1; flag_src = 2'd1; bus_in = 8'hF0; upd_mask = 4'h8; cond = 2'd0;
    cyc(); clr();
    chk("pop_z_only", 8'h90, 0, 0, 0);

    // ADD HL,rr
    wide_start = 1; wide_kind = 0; cond = 2'd1;
    cyc(); clr();
    carry_use = 1;
    chk("lo_ci0", 8'h90, 0, 1, 1);
    alu_valid = 1; alu_c = 1; alu_h = 0;
    upd_mask = 4'hF; flag_src = 2'd1; bus_in = 8'h00;
    cyc(); clr();
    chk("hi_ci1", 8'h90, 1, 1, 1);
    cyc();
    chk("hi_wait", 8'h90, 1, 1, 1);
    alu_valid = 1; alu_h = 1; alu_c = 0;
    cyc(); clr();
    chk("add_hl_done", 8'hA0, 0, 1, 0);
    carry_use = 0;

    // ADD SP,e with ignored updates during busy
    wide_start = 1; wide_kind = 1; cond = 2'd3;
    cyc(); clr();
    alu_valid = 1; alu_h = 1; alu_c = 1; alu_z = 1; op_n = 1;
    cyc(); clr();
    chk("sp_lo", 8'h30, 1, 1, 1);
    alu_valid = 1; alu_h = 0; alu_c = 0;
    upd_mask = 4'hF; flag_src = 2'd2; wide_start = 1;
    cyc(); clr();
    chk("sp_hi", 8'h30, 0, 1, 0);

    // SCF, then alu_valid=0 hold
    alu_valid = 1; flag_src = 2'd2; upd_mask = 4'hF;
    cyc(); clr();
    chk("scf", 8'h10, 0, 1, 0);
    alu_z = 1; alu_h = 1; upd_mask = 4'hF;
    cyc(); clr();
    chk("hold", 8'h10, 0, 1, 0);

    // Reset while in HI
    wide_start = 1; wide_kind = 0;
    cyc(); clr();
    alu_valid = 1; alu_c = 1;
    cyc(); clr();
    chk("hi_pre_rst", 8'h10, 1, 1, 1);
    cond = 2'd0;
    cyc();
    nRESET = 0;
    #1;
    chk("async_rst", 8'h00, 0, 0, 0);
    cyc();
    nRESET = 1; carry_use = 1;
    chk("idle_ci0", 8'h00, 0, 1, 0);
    wide_start = 1; wide_kind = 0;
    cyc(); clr();
    chk("restart_lo", 8'h00, 0, 1, 1);
    alu_valid = 1; alu_c = 0;
    cyc(); clr();
    chk("restart_hi", 8'h00, 0, 1, 1);
    alu_valid = 1; alu_h = 1; alu_c = 0;
    cyc(); clr();
    chk("restart_done", 8'h20, 0, 1, 0);

    repeat (2) @(negedge CLK);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
